// File: rtl/framebuffer_ctrl.sv
// framebuffer_ctrl: double-buffered framebuffer bank controller.
//
// Two pixel RAM banks alternate between front (read by the display) and back
// (written by the renderer). The renderer streams writes into the back bank
// via a valid/ready handshake; frame_done arms a swap that executes at the
// start of vertical blanking (vc == SWAP_LINE, hc == 0).
//
// Optional feature: define FB_CLEAR_ON_SWAP_EN to zero-fill the new back
// bank after each swap (one word per cycle, renderer stalled meanwhile).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   hc, vc             VGA horizontal / vertical counters
//   rd_addr            display read address (front bank)
//   req_valid/ready    renderer write handshake
//   req_addr/data      renderer write address / pixel
//   frame_done         pulse: back bank fully rendered
//   ram0_*, ram1_*     bank address / write enable / write data
//   rd_sel             front bank index
//   swap_pulse         one-cycle pulse on bank swap
//   frame_count        number of completed swaps (wraps)
module framebuffer_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FB_DEPTH  = 63360,
    parameter int unsigned SWAP_LINE = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic [15:0]       rd_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              frame_done,
    output logic [15:0]       ram0_addr,
    output logic              ram0_we,
    output logic [DATA_W-1:0] ram0_wdata,
    output logic [15:0]       ram1_addr,
    output logic              ram1_we,
    output logic [DATA_W-1:0] ram1_wdata,
    output logic              rd_sel,
    output logic              swap_pulse,
    output logic [7:0]        frame_count
);

    localparam logic [15:0] FbDepth  = 16'(FB_DEPTH);
    localparam logic [9:0]  SwapLine = 10'(SWAP_LINE);
`ifdef FB_CLEAR_ON_SWAP_EN
    localparam logic [15:0] FbLast   = 16'(FB_DEPTH - 1);
`endif

    typedef enum logic [1:0] {
        StAccept  = 2'd0,
        StPending = 2'd1
`ifdef FB_CLEAR_ON_SWAP_EN
        ,
        StClear   = 2'd2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic                rd_sel_q, rd_sel_d;
    logic                swap_pulse_q, swap_pulse_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [15:0]         back_addr_q, back_addr_d;
    logic                back_we_q, back_we_d;
    logic [DATA_W-1:0]   back_wdata_q, back_wdata_d;
`ifdef FB_CLEAR_ON_SWAP_EN
    logic [15:0]         clr_cnt_q, clr_cnt_d;
`endif

    logic vblank_start;
    logic do_swap;
    logic do_xfer;

    assign vblank_start = (vc == SwapLine) && (hc == 10'd0);
    assign do_swap      = (state_q == StPending) && vblank_start;
    assign do_xfer      = (state_q == StAccept) && req_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StAccept;
            rd_sel_q      <= 1'b0;
            swap_pulse_q  <= 1'b0;
            frame_count_q <= 8'd0;
            back_addr_q   <= 16'd0;
            back_we_q     <= 1'b0;
            back_wdata_q  <= '0;
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            rd_sel_q      <= rd_sel_d;
            swap_pulse_q  <= swap_pulse_d;
            frame_count_q <= frame_count_d;
            back_addr_q   <= back_addr_d;
            back_we_q     <= back_we_d;
            back_wdata_q  <= back_wdata_d;
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_cnt_q     <= clr_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        rd_sel_d      = rd_sel_q;
        swap_pulse_d  = 1'b0;
        frame_count_d = frame_count_q;
        back_addr_d   = back_addr_q;
        back_we_d     = 1'b0;
        back_wdata_d  = back_wdata_q;
`ifdef FB_CLEAR_ON_SWAP_EN
        clr_cnt_d     = clr_cnt_q;
`endif

        unique case (state_q)
            StAccept: begin
                if (frame_done) state_d = StPending;
            end
            StPending: begin
`ifdef FB_CLEAR_ON_SWAP_EN
                if (vblank_start) state_d = StClear;
`else
                if (vblank_start) state_d = StAccept;
`endif
            end
`ifdef FB_CLEAR_ON_SWAP_EN
            StClear: begin
                if (clr_cnt_q == FbLast) state_d = StAccept;
            end
`endif
            default: state_d = StAccept;
        endcase

        // Out-of-range writes complete the handshake but are dropped.
        if (do_xfer) begin
            back_addr_d  = req_addr;
            back_wdata_d = req_data;
            back_we_d    = (req_addr < FbDepth);
        end

        if (do_swap) begin
            rd_sel_d      = ~rd_sel_q;
            swap_pulse_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
`ifdef FB_CLEAR_ON_SWAP_EN
            // First clear word is issued on the swap edge so every CLEAR
            // cycle carries exactly one write (address == clr_cnt_q).
            clr_cnt_d    = 16'd0;
            back_addr_d  = 16'd0;
            back_wdata_d = '0;
            back_we_d    = 1'b1;
`endif
        end

`ifdef FB_CLEAR_ON_SWAP_EN
        if ((state_q == StClear) && (clr_cnt_q != FbLast)) begin
            clr_cnt_d    = clr_cnt_q + 16'd1;
            back_addr_d  = clr_cnt_q + 16'd1;
            back_wdata_d = '0;
            back_we_d    = 1'b1;
        end
`endif
    end

    // Outputs: front bank follows rd_addr directly, back bank is registered.
    always_comb begin
        req_ready   = (state_q == StAccept);
        rd_sel      = rd_sel_q;
        swap_pulse  = swap_pulse_q;
        frame_count = frame_count_q;
        if (rd_sel_q) begin
            ram0_addr  = back_addr_q;
            ram0_we    = back_we_q;
            ram0_wdata = back_wdata_q;
            ram1_addr  = rd_addr;
            ram1_we    = 1'b0;
            ram1_wdata = '0;
        end else begin
            ram0_addr  = rd_addr;
            ram0_we    = 1'b0;
            ram0_wdata = '0;
            ram1_addr  = back_addr_q;
            ram1_we    = back_we_q;
            ram1_wdata = back_wdata_q;
        end
    end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
module tb_framebuffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hc, vc;
    logic [15:0] rd_addr;
    logic        req_valid, req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        frame_done;
    logic [15:0] ram0_addr, ram1_addr;
    logic        ram0_we, ram1_we;
    logic [7:0]  ram0_wdata, ram1_wdata;
    logic        rd_sel, swap_pulse;
    logic [7:0]  frame_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    framebuffer_ctrl #(
        .DATA_W   (8),
        .FB_DEPTH (63360),
        .SWAP_LINE(480)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .rd_addr    (rd_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .frame_done (frame_done),
        .ram0_addr  (ram0_addr),
        .ram1_addr  (ram1_addr),
        .ram0_we    (ram0_we),
        .ram1_we    (ram1_we),
        .ram0_wdata (ram0_wdata),
        .ram1_wdata (ram1_wdata),
        .rd_sel     (rd_sel),
        .swap_pulse (swap_pulse),
        .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        hc         = 10'd5;
        vc         = 10'd0;
        rd_addr    = 16'h1234;
        req_valid  = 1'b0;
        req_addr   = 16'h0;
        req_data   = 8'h0;
        frame_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        chk("rst_swap", 32'(swap_pulse), 32'd0);
        chk("rst_fcount", 32'(frame_count), 32'd0);
        chk("rst_we0", 32'(ram0_we), 32'd0);
        chk("rst_we1", 32'(ram1_we), 32'd0);
        chk("rst_addr1", 32'(ram1_addr), 32'h0);
        chk("rst_wdata1", 32'(ram1_wdata), 32'h0);
        chk("rst_addr0", 32'(ram0_addr), 32'h1234);
        rst = 1'b0;
        tick();

        // Basic transfer into back bank (bank1)
        req_valid = 1'b1; req_addr = 16'h0010; req_data = 8'hE0;
        #1;
        chk("xfer_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("xfer_addr1", 32'(ram1_addr), 32'h0010);
        chk("xfer_we1", 32'(ram1_we), 32'd1);
        chk("xfer_wdata1", 32'(ram1_wdata), 32'hE0);
        chk("xfer_we0", 32'(ram0_we), 32'd0);
        chk("xfer_addr0", 32'(ram0_addr), 32'h1234);
        rd_addr = 16'h0042;
        #1;
        chk("front_comb", 32'(ram0_addr), 32'h0042);
        tick();
        chk("xfer_we1_1cyc", 32'(ram1_we), 32'd0);

        // vblank in ACCEPT must not swap
        vc = 10'd480; hc = 10'd0;
        tick();
        vc = 10'd0; hc = 10'd5;
        chk("noswap_pulse", 32'(swap_pulse), 32'd0);
        chk("noswap_rd_sel", 32'(rd_sel), 32'd0);
        chk("noswap_fcount", 32'(frame_count), 32'd0);
        chk("noswap_ready", 32'(req_ready), 32'd1);

        // Out-of-range address is accepted but dropped
        req_valid = 1'b1; req_addr = 16'd63360; req_data = 8'h55;
        #1;
        chk("oor_ready", 32'(req_ready), 32'd1);
        tick();
        chk("oor_we0", 32'(ram0_we), 32'd0);
        chk("oor_we1", 32'(ram1_we), 32'd0);
        // Last valid address still writes
        req_addr = 16'd63359; req_data = 8'hA5;
        tick();
        chk("last_we1", 32'(ram1_we), 32'd1);
        chk("last_addr1", 32'(ram1_addr), 32'd63359);
        chk("last_wdata1", 32'(ram1_wdata), 32'hA5);

        // frame_done with simultaneous transfer
        frame_done = 1'b1; req_addr = 16'h0020; req_data = 8'h7A;
        tick();
        frame_done = 1'b0; req_valid = 1'b0;
        chk("fd_ready", 32'(req_ready), 32'd0);
        chk("fd_we1", 32'(ram1_we), 32'd1);
        chk("fd_addr1", 32'(ram1_addr), 32'h0020);
        chk("fd_wdata1", 32'(ram1_wdata), 32'h7A);
        // Requests in PENDING are not accepted
        req_valid = 1'b1; req_addr = 16'h0030;
        tick();
        req_valid = 1'b0;
        chk("pend_ready", 32'(req_ready), 32'd0);
        chk("pend_we1", 32'(ram1_we), 32'd0);
        // hc != 0 on swap line must not swap
        vc = 10'd480; hc = 10'd1;
        tick();
        chk("pend_hc1_swap", 32'(swap_pulse), 32'd0);
        chk("pend_hc1_rd_sel", 32'(rd_sel), 32'd0);

        // Swap
        hc = 10'd0;
        tick();
        vc = 10'd0; hc = 10'd5;
        chk("swap_pulse", 32'(swap_pulse), 32'd1);
        chk("swap_rd_sel", 32'(rd_sel), 32'd1);
        chk("swap_fcount", 32'(frame_count), 32'd1);
        chk("swap_front1", 32'(ram1_addr), 32'h0042);
        chk("swap_front_we1", 32'(ram1_we), 32'd0);
`ifdef FB_CLEAR_ON_SWAP_EN
        begin
            int bad = 0;
            chk("clr_ready0", 32'(req_ready), 32'd0);
            chk("clr_first_we0", 32'(ram0_we), 32'd1);
            chk("clr_first_addr0", 32'(ram0_addr), 32'd0);
            for (int k = 1; k < 63360; k++) begin
                tick();
                if (ram0_we !== 1'b1 || ram0_addr !== 16'(k) || ram0_wdata !== 8'h00 ||
                    req_ready !== 1'b0 || ram1_we !== 1'b0) begin
                    bad++;
                end
            end
            chk("clr_sweep_errors", 32'(bad), 32'd0);
            tick();
            chk("clr_done_ready", 32'(req_ready), 32'd1);
            chk("clr_done_we0", 32'(ram0_we), 32'd0);
        end
`else
        chk("swap_ready", 32'(req_ready), 32'd1);
        tick();
        chk("swap_pulse_1cyc", 32'(swap_pulse), 32'd0);
`endif

        // New back bank is bank0
        req_valid = 1'b1; req_addr = 16'h0100; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        chk("b0_we0", 32'(ram0_we), 32'd1);
        chk("b0_addr0", 32'(ram0_addr), 32'h0100);
        chk("b0_wdata0", 32'(ram0_wdata), 32'h3C);
        chk("b0_we1", 32'(ram1_we), 32'd0);
        chk("b0_front1", 32'(ram1_addr), 32'h0042);

        // Second swap returns front to bank0
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        vc = 10'd480; hc = 10'd0;
        tick();
        vc = 10'd0; hc = 10'd5;
        chk("swap2_pulse", 32'(swap_pulse), 32'd1);
        chk("swap2_rd_sel", 32'(rd_sel), 32'd0);
        chk("swap2_fcount", 32'(frame_count), 32'd2);

`ifdef FB_CLEAR_ON_SWAP_EN
        // Reset after 100 clear writes aborts the clear immediately
        for (int k = 1; k < 100; k++) tick();
        chk("clr2_addr_99", 32'(ram1_addr), 32'd99);
        rst = 1'b1;
        #1;
        chk("abort_we0", 32'(ram0_we), 32'd0);
        chk("abort_we1", 32'(ram1_we), 32'd0);
        chk("abort_rd_sel", 32'(rd_sel), 32'd0);
        chk("abort_fcount", 32'(frame_count), 32'd0);
`else
        // Reset mid-PENDING aborts
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("pend2_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rd_sel", 32'(rd_sel), 32'd0);
        chk("abort_fcount", 32'(frame_count), 32'd0);
        chk("abort_we1", 32'(ram1_we), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_we0", 32'(ram0_we), 32'd0);
        chk("post_rst_we1", 32'(ram1_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
